fpga_tdp_ram_pipe: RTL and testbench

// - Parametrised true-dual-port RAM: byte write enables, word-aligned byte addressing.
// - Selectable read latency (1 or 2 cycles) with per-port read-valid outputs.
// - Per-port write mode (READ_FIRST / WRITE_FIRST); defined dual-write collision resolution and flag.
// - Shared instruction/data memory between core-side and debug/loader-side masters.

---
 rtl/fpga_tdp_ram_pipe_if.sv | 36 +++
 rtl/fpga_tdp_ram_pipe.sv | 178 +++++++++++++++++
 tb/tb_fpga_tdp_ram_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_tdp_ram_pipe_if.sv
// ---------------------------------------------------------------------------
// fpga_tdp_ram_pipe_if
// One access port of the true-dual-port RAM. A master drives a request;
// the RAM (slave) returns a word with a valid strobe.
//   en     : access request (read or write)
//   we     : 1 = write, 0 = read
//   addr   : byte address, low byte-offset bits ignored
//   wdata  : write data
//   be     : byte enables, used only for writes
//   rdata  : returned word, held while rvalid is low
//   rvalid : one-cycle strobe per returned word
// ---------------------------------------------------------------------------
interface fpga_tdp_ram_pipe_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                      en;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;

  // Requesting side of the port
  modport master (
    output en, we, addr, wdata, be,
    input  rdata, rvalid
  );

  // RAM side of the port
  modport slave (
    input  en, we, addr, wdata, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/fpga_tdp_ram_pipe.sv
// ---------------------------------------------------------------------------
// fpga_tdp_ram_pipe
// True-dual-port RAM shared between the core and the debug/loader master.
// Byte write enables, word-aligned byte addressing, 1 or 2 cycle read
// latency, per-port READ_FIRST/WRITE_FIRST, and a defined dual-write
// collision policy with a one-cycle collision flag.
//   clk_i       : clock, all logic on posedge
//   rst_i       : async active-high reset; clears pipeline and flags only
//   port_a      : access port A (slave modport)
//   port_b      : access port B (slave modport)
//   collision_o : pulse when both ports wrote the same byte of a word
// Pipeline: edge N samples the request, edge N+1 performs the array
// access (write commit + read capture), edge N+2 is the optional extra
// output register when READ_LATENCY = 2.
// ---------------------------------------------------------------------------
module fpga_tdp_ram_pipe #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0,
  parameter int PRIO_A       = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fpga_tdp_ram_pipe_if.slave  port_a,
  fpga_tdp_ram_pipe_if.slave  port_b,
  output logic                collision_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = ADDR_WIDTH - OFF;
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sampled requests (stage 0)
  logic                  s0_en_a, s0_we_a, s0_en_b, s0_we_b;
  logic [IDX_W-1:0]      s0_idx_a, s0_idx_b;
  logic [DATA_WIDTH-1:0] s0_wdata_a, s0_wdata_b;
  logic [BE_W-1:0]       s0_be_a, s0_be_b;

  // Array access signals
  logic                  wr_a, wr_b, same_word;
  logic [BE_W-1:0]       hit_a, hit_b, clash;
  logic [DATA_WIDTH-1:0] old_a, old_b, fin_a, fin_b, rd_a, rd_b;

  // Stage 1 results
  logic                  v1_a, v1_b;
  logic [DATA_WIDTH-1:0] d1_a, d1_b;

  // Byte-offset address bits select nothing inside a word.
  if (OFF > 0) begin : g_unused_offset
    logic unused_offset_bits;
    assign unused_offset_bits = ^{port_a.addr[OFF-1:0], port_b.addr[OFF-1:0]};
  end

  // Request sampling. Reset clears the enables, so anything presented
  // while rst_i is high (writes included) never reaches the array, and
  // an asynchronous reset kills requests already sampled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_en_a    <= 1'b0;
      s0_we_a    <= 1'b0;
      s0_idx_a   <= '0;
      s0_wdata_a <= '0;
      s0_be_a    <= '0;
      s0_en_b    <= 1'b0;
      s0_we_b    <= 1'b0;
      s0_idx_b   <= '0;
      s0_wdata_b <= '0;
      s0_be_b    <= '0;
    end else begin
      s0_en_a    <= port_a.en;
      s0_we_a    <= port_a.we;
      s0_idx_a   <= port_a.addr[ADDR_WIDTH-1:OFF];
      s0_wdata_a <= port_a.wdata;
      s0_be_a    <= port_a.be;
      s0_en_b    <= port_b.en;
      s0_we_b    <= port_b.we;
      s0_idx_b   <= port_b.addr[ADDR_WIDTH-1:OFF];
      s0_wdata_b <= port_b.wdata;
      s0_be_b    <= port_b.be;
    end
  end

  assign wr_a      = s0_en_a & s0_we_a;
  assign wr_b      = s0_en_b & s0_we_b;
  assign hit_a     = {BE_W{wr_a}} & s0_be_a;
  assign hit_b     = {BE_W{wr_b}} & s0_be_b;
  assign same_word = (s0_idx_a == s0_idx_b);
  assign old_a     = mem[s0_idx_a];
  assign old_b     = mem[s0_idx_b];

  // Final stored word at each port's index. When both ports hit the same
  // word, each view folds in the other port's bytes, with the priority
  // port owning bytes enabled on both sides, so fin_a == fin_b then and
  // the two array writes below agree.
  always_comb begin
    fin_a = old_a;
    fin_b = old_b;
    clash = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (hit_a[i] && !(same_word && hit_b[i] && PRIO_A == 0))
        fin_a[8*i +: 8] = s0_wdata_a[8*i +: 8];
      else if (same_word && hit_b[i])
        fin_a[8*i +: 8] = s0_wdata_b[8*i +: 8];

      if (hit_b[i] && !(same_word && hit_a[i] && PRIO_A != 0))
        fin_b[8*i +: 8] = s0_wdata_b[8*i +: 8];
      else if (same_word && hit_a[i])
        fin_b[8*i +: 8] = s0_wdata_a[8*i +: 8];

      clash[i] = same_word & hit_a[i] & hit_b[i];
    end
  end

  // A reading port always sees the pre-write word; only a writing port in
  // WRITE_FIRST mode returns the merged result.
  assign rd_a = (WRITE_MODE_A != 0 && wr_a) ? fin_a : old_a;
  assign rd_b = (WRITE_MODE_B != 0 && wr_b) ? fin_b : old_b;

  // Array write; the array is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_a) mem[s0_idx_a] <= fin_a;
    if (wr_b) mem[s0_idx_b] <= fin_b;
  end

  // Stage 1: captured read word, valid and collision flag. Data registers
  // only load on a valid access so the bus holds still between words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_a        <= 1'b0;
      v1_b        <= 1'b0;
      d1_a        <= '0;
      d1_b        <= '0;
      collision_o <= 1'b0;
    end else begin
      v1_a        <= s0_en_a;
      v1_b        <= s0_en_b;
      collision_o <= |clash;
      if (s0_en_a) d1_a <= rd_a;
      if (s0_en_b) d1_b <= rd_b;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_a, v2_b;
    logic [DATA_WIDTH-1:0] d2_a, d2_b;

    // Extra output register stage, same hold-when-idle behaviour.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v2_a <= 1'b0;
        v2_b <= 1'b0;
        d2_a <= '0;
        d2_b <= '0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        if (v1_a) d2_a <= d1_a;
        if (v1_b) d2_b <= d1_b;
      end
    end

    assign port_a.rvalid = v2_a;
    assign port_a.rdata  = d2_a;
    assign port_b.rvalid = v2_b;
    assign port_b.rdata  = d2_b;
  end else begin : g_lat1
    assign port_a.rvalid = v1_a;
    assign port_a.rdata  = d1_a;
    assign port_b.rvalid = v1_b;
    assign port_b.rdata  = d1_b;
  end

endmodule

// File: tb/tb_fpga_tdp_ram_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpga_tdp_ram_pipe
// Two RAM instances driven from shared per-port stimulus arrays:
//   dut1 : READ_LATENCY=1, A WRITE_FIRST, B READ_FIRST, PRIO_A=1
//   dut2 : READ_LATENCY=2, A READ_FIRST,  B WRITE_FIRST, PRIO_A=0
// Port index: 0 = dut1.A, 1 = dut1.B, 2 = dut2.A, 3 = dut2.B.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fpga_tdp_ram_pipe;

  logic clk;
  logic rst;

  logic        en_v    [4];
  logic        we_v    [4];
  logic [17:0] addr_v  [4];
  logic [31:0] wdata_v [4];
  logic [3:0]  be_v    [4];
  logic [31:0] rdata_v [4];
  logic        rvalid_v[4];
  logic        coll1, coll2;

  int checks = 0;
  int errors = 0;

  fpga_tdp_ram_pipe_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ifa1 ();
  fpga_tdp_ram_pipe_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ifb1 ();
  fpga_tdp_ram_pipe_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ifa2 ();
  fpga_tdp_ram_pipe_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) ifb2 ();

  assign ifa1.en = en_v[0]; assign ifa1.we = we_v[0]; assign ifa1.addr = addr_v[0];
  assign ifa1.wdata = wdata_v[0]; assign ifa1.be = be_v[0];
  assign ifb1.en = en_v[1]; assign ifb1.we = we_v[1]; assign ifb1.addr = addr_v[1];
  assign ifb1.wdata = wdata_v[1]; assign ifb1.be = be_v[1];
  assign ifa2.en = en_v[2]; assign ifa2.we = we_v[2]; assign ifa2.addr = addr_v[2];
  assign ifa2.wdata = wdata_v[2]; assign ifa2.be = be_v[2];
  assign ifb2.en = en_v[3]; assign ifb2.we = we_v[3]; assign ifb2.addr = addr_v[3];
  assign ifb2.wdata = wdata_v[3]; assign ifb2.be = be_v[3];

  assign rdata_v[0] = ifa1.rdata; assign rvalid_v[0] = ifa1.rvalid;
  assign rdata_v[1] = ifb1.rdata; assign rvalid_v[1] = ifb1.rvalid;
  assign rdata_v[2] = ifa2.rdata; assign rvalid_v[2] = ifa2.rvalid;
  assign rdata_v[3] = ifb2.rdata; assign rvalid_v[3] = ifb2.rvalid;

  fpga_tdp_ram_pipe #(
    .ADDR_WIDTH(18), .DATA_WIDTH(32), .READ_LATENCY(1),
    .WRITE_MODE_A(1), .WRITE_MODE_B(0), .PRIO_A(1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .port_a(ifa1), .port_b(ifb1), .collision_o(coll1)
  );

  fpga_tdp_ram_pipe #(
    .ADDR_WIDTH(18), .DATA_WIDTH(32), .READ_LATENCY(2),
    .WRITE_MODE_A(0), .WRITE_MODE_B(1), .PRIO_A(0)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .port_a(ifa2), .port_b(ifb2), .collision_o(coll2)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one port's request lines
  task automatic applyStimulus(input int p, input logic en, input logic we,
                               input logic [17:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    en_v[p]    = en;
    we_v[p]    = we;
    addr_v[p]  = addr;
    wdata_v[p] = wdata;
    be_v[p]    = be;
  endtask

  task automatic idlePort(input int p);
    applyStimulus(p, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full-pipeline write on both A ports, then drain
  task automatic writeBoth(input logic [17:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(0, 1'b1, 1'b1, addr, data, be);
    applyStimulus(2, 1'b1, 1'b1, addr, data, be);
    tick(1);
    idlePort(0);
    idlePort(2);
    tick(4);
  endtask

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 4; p++) idlePort(p);

    // Reset state
    tick(3);
    for (int p = 0; p < 4; p++) begin
      checkOutput("rst_rvalid", 32'(rvalid_v[p]), 32'h0);
      checkOutput("rst_rdata", rdata_v[p], 32'h0);
    end
    checkOutput("rst_coll1", 32'(coll1), 32'h0);
    checkOutput("rst_coll2", 32'(coll2), 32'h0);
    rst = 1'b0;
    tick(1);

    // Write A 0x100, read B 0x100 next cycle; latency per instance
    applyStimulus(0, 1'b1, 1'b1, 18'h100, 32'hDEADBEEF, 4'hF);
    applyStimulus(2, 1'b1, 1'b1, 18'h100, 32'hDEADBEEF, 4'hF);
    tick(1);
    idlePort(0);
    idlePort(2);
    applyStimulus(1, 1'b1, 1'b0, 18'h100, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h100, 32'h0, 4'h0);
    tick(1);
    idlePort(1);
    idlePort(3);
    checkOutput("t1_a1_valid", 32'(rvalid_v[0]), 32'h1);
    checkOutput("t1_a1_data", rdata_v[0], 32'hDEADBEEF);
    checkOutput("t1_b1_early", 32'(rvalid_v[1]), 32'h0);
    checkOutput("t1_a2_early", 32'(rvalid_v[2]), 32'h0);
    tick(1);
    checkOutput("t1_b1_valid", 32'(rvalid_v[1]), 32'h1);
    checkOutput("t1_b1_data", rdata_v[1], 32'hDEADBEEF);
    checkOutput("t1_a1_drop", 32'(rvalid_v[0]), 32'h0);
    checkOutput("t1_a1_hold", rdata_v[0], 32'hDEADBEEF);
    checkOutput("t1_a2_valid", 32'(rvalid_v[2]), 32'h1);
    checkOutput("t1_b2_early", 32'(rvalid_v[3]), 32'h0);
    tick(1);
    checkOutput("t1_b2_valid", 32'(rvalid_v[3]), 32'h1);
    checkOutput("t1_b2_data", rdata_v[3], 32'hDEADBEEF);
    checkOutput("t1_a2_drop", 32'(rvalid_v[2]), 32'h0);
    tick(2);

    // Same-port read-during-write and cross-port read of the same word
    writeBoth(18'h200, 32'h11223344, 4'hF);
    for (int p = 0; p < 4; p++) begin
      if (p == 0 || p == 2) applyStimulus(p, 1'b1, 1'b1, 18'h200, 32'hAAAA5566, 4'h3);
      else                  applyStimulus(p, 1'b1, 1'b0, 18'h200, 32'h0, 4'h0);
    end
    tick(1);
    for (int p = 0; p < 4; p++) idlePort(p);
    tick(1);
    checkOutput("t2_a1_wf", rdata_v[0], 32'h11225566);
    checkOutput("t2_b1_old", rdata_v[1], 32'h11223344);
    tick(1);
    checkOutput("t2_a2_rf", rdata_v[2], 32'h11223344);
    checkOutput("t2_b2_old", rdata_v[3], 32'h11223344);
    applyStimulus(1, 1'b1, 1'b0, 18'h200, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h200, 32'h0, 4'h0);
    tick(1);
    idlePort(1);
    idlePort(3);
    tick(1);
    checkOutput("t2_b1_stored", rdata_v[1], 32'h11225566);
    tick(1);
    checkOutput("t2_b2_stored", rdata_v[3], 32'h11225566);
    tick(2);

    // Dual write, overlapping byte 0: dut1 A wins, dut2 B wins
    writeBoth(18'h300, 32'h12345678, 4'hF);
    applyStimulus(0, 1'b1, 1'b1, 18'h300, 32'h000000AA, 4'h1);
    applyStimulus(1, 1'b1, 1'b1, 18'h300, 32'h000000BB, 4'h1);
    applyStimulus(2, 1'b1, 1'b1, 18'h300, 32'h000000AA, 4'h1);
    applyStimulus(3, 1'b1, 1'b1, 18'h300, 32'h000000BB, 4'h1);
    tick(1);
    for (int p = 0; p < 4; p++) idlePort(p);
    checkOutput("t3_coll1_early", 32'(coll1), 32'h0);
    tick(1);
    checkOutput("t3_coll1", 32'(coll1), 32'h1);
    checkOutput("t3_coll2", 32'(coll2), 32'h1);
    checkOutput("t3_a1_wf", rdata_v[0], 32'h123456AA);
    checkOutput("t3_b1_rf", rdata_v[1], 32'h12345678);
    tick(1);
    checkOutput("t3_coll1_end", 32'(coll1), 32'h0);
    checkOutput("t3_coll2_end", 32'(coll2), 32'h0);
    checkOutput("t3_a2_rf", rdata_v[2], 32'h12345678);
    checkOutput("t3_b2_wf", rdata_v[3], 32'h123456BB);
    tick(2);

    // Dual write, disjoint byte enables: legal merge, no flag
    applyStimulus(0, 1'b1, 1'b1, 18'h300, 32'h00000011, 4'h1);
    applyStimulus(1, 1'b1, 1'b1, 18'h300, 32'h00002200, 4'h2);
    applyStimulus(2, 1'b1, 1'b1, 18'h300, 32'h00000011, 4'h1);
    applyStimulus(3, 1'b1, 1'b1, 18'h300, 32'h00002200, 4'h2);
    tick(1);
    for (int p = 0; p < 4; p++) idlePort(p);
    tick(1);
    checkOutput("t4_coll1", 32'(coll1), 32'h0);
    checkOutput("t4_coll2", 32'(coll2), 32'h0);
    checkOutput("t4_a1_wf", rdata_v[0], 32'h12342211);
    checkOutput("t4_b1_rf", rdata_v[1], 32'h123456AA);
    tick(1);
    checkOutput("t4_a2_rf", rdata_v[2], 32'h123456BB);
    checkOutput("t4_b2_wf", rdata_v[3], 32'h12342211);
    applyStimulus(1, 1'b1, 1'b0, 18'h300, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h302, 32'h0, 4'h0);
    tick(1);
    idlePort(1);
    idlePort(3);
    tick(1);
    checkOutput("t4_b1_stored", rdata_v[1], 32'h12342211);
    tick(1);
    checkOutput("t4_b2_stored", rdata_v[3], 32'h12342211);
    tick(2);

    // Back-to-back reads on dut2 port A, first address unaligned
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, 1'b1, 1'b1, 18'h400 + 18'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      tick(1);
    end
    idlePort(2);
    tick(4);
    for (int j = 0; j < 11; j++) begin
      if (j < 8) applyStimulus(2, 1'b1, 1'b0, 18'h400 + 18'(4 * j) + ((j == 0) ? 18'd3 : 18'd0), 32'h0, 4'h0);
      else       idlePort(2);
      tick(1);
      if (j >= 2 && j < 10) begin
        checkOutput("t5_valid", 32'(rvalid_v[2]), 32'h1);
        checkOutput("t5_data", rdata_v[2], 32'hC0DE0000 + 32'(j - 2));
      end else begin
        checkOutput("t5_idle", 32'(rvalid_v[2]), 32'h0);
      end
    end
    tick(2);

    // Reset with reads in flight on dut2, plus a write attempted during reset
    applyStimulus(2, 1'b1, 1'b0, 18'h100, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h200, 32'h0, 4'h0);
    tick(1);
    applyStimulus(2, 1'b1, 1'b0, 18'h300, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h300, 32'h0, 4'h0);
    tick(1);
    rst = 1'b1;
    idlePort(2);
    idlePort(3);
    applyStimulus(0, 1'b1, 1'b1, 18'h100, 32'h00000000, 4'hF);
    #1;
    checkOutput("t6_a2_valid", 32'(rvalid_v[2]), 32'h0);
    checkOutput("t6_b2_valid", 32'(rvalid_v[3]), 32'h0);
    checkOutput("t6_a2_data", rdata_v[2], 32'h0);
    checkOutput("t6_b2_data", rdata_v[3], 32'h0);
    checkOutput("t6_a1_data", rdata_v[0], 32'h0);
    checkOutput("t6_coll1", 32'(coll1), 32'h0);
    checkOutput("t6_coll2", 32'(coll2), 32'h0);
    tick(1);
    rst = 1'b0;
    idlePort(0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checkOutput("t6_stale_a2", 32'(rvalid_v[2]), 32'h0);
      checkOutput("t6_stale_b2", 32'(rvalid_v[3]), 32'h0);
      checkOutput("t6_stale_a1", 32'(rvalid_v[0]), 32'h0);
    end
    applyStimulus(1, 1'b1, 1'b0, 18'h100, 32'h0, 4'h0);
    applyStimulus(3, 1'b1, 1'b0, 18'h200, 32'h0, 4'h0);
    tick(1);
    idlePort(1);
    idlePort(3);
    tick(1);
    checkOutput("t6_b1_valid", 32'(rvalid_v[1]), 32'h1);
    checkOutput("t6_b1_kept", rdata_v[1], 32'hDEADBEEF);
    tick(1);
    checkOutput("t6_b2_valid", 32'(rvalid_v[3]), 32'h1);
    checkOutput("t6_b2_kept", rdata_v[3], 32'h11225566);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
